// File: rtl/execute_stage.sv
// execute_stage: EX stage of the MIPS datapath.
//
// Computes the ALU result, effective address or branch/jump target plus the
// branch condition for one instruction at a time and presents them to the
// Memory stage through a registered valid/ready output. It also owns the
// HI/LO registers and an iterative shift-add MULTU unit.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready decode -> EX handshake
//   Op_in, Func_in    opcode and funct fields
//   NPC_in            PC+4 of the instruction
//   A_in, B_in        rs and rt operands
//   Imm_in            sign-extended immediate (raw jump target in [25:0])
//   out_valid/out_ready EX -> MEM handshake
//   Op, NPC, Data     opcode, PC+4 and rt passed through
//   Res               ALU result / address / target
//   cond              branch or jump taken
//   illegal           unsupported opcode/funct
//
// FSM states
//   state | meaning
//   IDLE  | accepting instructions, single-cycle ops load the output directly
//   MUL   | MULTU in progress, MUL_BITS multiplier bits retired per cycle
//   DONE  | product written to HI/LO, waiting for a free output register

module execute_stage #(
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  Op_in,
  input  logic [5:0]  Func_in,
  input  logic [31:0] NPC_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  input  logic [31:0] Imm_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  Op,
  output logic [31:0] NPC,
  output logic [31:0] Res,
  output logic [31:0] Data,
  output logic        cond,
  output logic        illegal
);

  localparam int MUL_CYCLES = 32 / MUL_BITS;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] hi, lo;
  logic [63:0] acc, acc_nxt, partial;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  cnt;
  logic [5:0]  m_op;
  logic [31:0] m_npc, m_b;

  logic [31:0] alu_res;
  logic        alu_cond, alu_ill, is_multu;
  logic        out_free, accept, ld_alu, ld_mul;
  logic [31:0] mul_res;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath and decode
  always_comb begin
    alu_res  = '0;
    alu_cond = 1'b0;
    alu_ill  = 1'b0;
    is_multu = 1'b0;
    if (Op_in == OP_RTYPE) begin
      case (Func_in)
        FN_ADD:   alu_res = A_in + B_in;
        FN_SUB:   alu_res = A_in - B_in;
        FN_AND:   alu_res = A_in & B_in;
        FN_OR:    alu_res = A_in | B_in;
        FN_XOR:   alu_res = A_in ^ B_in;
        FN_SLT:   alu_res = ($signed(A_in) < $signed(B_in)) ? 32'd1 : 32'd0;
        FN_MFHI:  alu_res = hi;
        FN_MFLO:  alu_res = lo;
        FN_MULTU: is_multu = 1'b1;
        default:  alu_ill = 1'b1;
      endcase
    end else begin
      case (Op_in)
        OP_ADDI:       alu_res = A_in + Imm_in;
        OP_ANDI:       alu_res = A_in & {16'h0000, Imm_in[15:0]};
        OP_ORI:        alu_res = A_in | {16'h0000, Imm_in[15:0]};
        OP_LW, OP_SW:  alu_res = A_in + Imm_in;
        OP_BEQ: begin
          alu_res  = NPC_in + {Imm_in[29:0], 2'b00};
          alu_cond = (A_in == B_in);
        end
        OP_BNE: begin
          alu_res  = NPC_in + {Imm_in[29:0], 2'b00};
          alu_cond = (A_in != B_in);
        end
        OP_J: begin
          alu_res  = {NPC_in[31:28], Imm_in[25:0], 2'b00};
          alu_cond = 1'b1;
        end
        default:       alu_ill = 1'b1;
      endcase
    end
  end

  // One multiplier digit of MUL_BITS bits worth of shifted multiplicand
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  assign acc_nxt = acc + partial;

  // On the final MUL cycle the product is not yet in lo, so take it from the adder
  assign mul_res = (state == MUL) ? acc_nxt[31:0] : lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_alu    = 1'b0;
    ld_mul    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_multu) state_nxt = MUL;
          else          ld_alu    = 1'b1;
        end
      end
      MUL: begin
        if (cnt == 5'd0) begin
          if (out_free) begin
            ld_mul    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_free) begin
          ld_mul    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplier datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      m_op   <= '0;
      m_npc  <= '0;
      m_b    <= '0;
    end else if (accept && is_multu) begin
      acc    <= '0;
      mcand  <= {32'h0, A_in};
      mplier <= B_in;
      cnt    <= 5'(MUL_CYCLES - 1);
      m_op   <= Op_in;
      m_npc  <= NPC_in;
      m_b    <= B_in;
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier >> MUL_BITS;
      cnt    <= cnt - 5'd1;
      if (cnt == 5'd0) {hi, lo} <= acc_nxt;
    end
  end

  // EX/MEM output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Op        <= '0;
      NPC       <= '0;
      Res       <= '0;
      Data      <= '0;
      cond      <= 1'b0;
      illegal   <= 1'b0;
    end else if (ld_alu) begin
      out_valid <= 1'b1;
      Op        <= Op_in;
      NPC       <= NPC_in;
      Res       <= alu_res;
      Data      <= B_in;
      cond      <= alu_cond;
      illegal   <= alu_ill;
    end else if (ld_mul) begin
      out_valid <= 1'b1;
      Op        <= m_op;
      NPC       <= m_npc;
      Res       <= mul_res;
      Data      <= m_b;
      cond      <= 1'b0;
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed scenarios plus randomized instruction streams
// for execute_stage, checked against a reference model of the instruction
// semantics kept as a queue of expected EX/MEM results.

module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  Op_in, Func_in;
  logic [31:0] NPC_in, A_in, B_in, Imm_in;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  Op;
  logic [31:0] NPC, Res, Data;
  logic        cond, illegal;

  int tests = 0;
  int fails = 0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  execute_stage #(.MUL_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Op_in(Op_in), .Func_in(Func_in), .NPC_in(NPC_in),
    .A_in(A_in), .B_in(B_in), .Imm_in(Imm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .Op(Op), .NPC(NPC), .Res(Res), .Data(Data),
    .cond(cond), .illegal(illegal)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] npc, res, data;
    logic        cond, ill, is_mul;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mhi = '0, mlo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics; hi/lo are the values the instruction must observe
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] npc, a, b, imm, hi, lo);
    exp_t e;
    e.op = op; e.npc = npc; e.data = b; e.res = 0; e.cond = 0; e.ill = 0; e.is_mul = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: e.res = a + b;
        6'h22: e.res = a - b;
        6'h24: e.res = a & b;
        6'h25: e.res = a | b;
        6'h26: e.res = a ^ b;
        6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h10: e.res = hi;
        6'h12: e.res = lo;
        6'h19: begin e.is_mul = 1; e.res = lo; end
        default: e.ill = 1;
      endcase
    end else begin
      case (op)
        6'h08, 6'h23, 6'h2B: e.res = a + imm;
        6'h0C: e.res = a & (imm & 32'h0000FFFF);
        6'h0D: e.res = a | (imm & 32'h0000FFFF);
        6'h04: begin e.res = npc + imm * 4; e.cond = (a == b); end
        6'h05: begin e.res = npc + imm * 4; e.cond = (a != b); end
        6'h02: begin e.res = (npc & 32'hF0000000) | ((imm & 32'h03FFFFFF) * 4); e.cond = 1; end
        default: e.ill = 1;
      endcase
    end
    return e;
  endfunction

  // Compare process: samples 1 time unit before each rising edge
  initial begin : monitor
    exp_t e;
    bit   mul_busy   = 0;
    bit   want_valid = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        exp_q.delete();
        mhi = '0; mlo = '0;
        mul_busy = 0; want_valid = 0;
        continue;
      end
      if (want_valid) begin
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        want_valid = 0;
      end
      if (mul_busy && out_valid && exp_q.size() > 0 && exp_q[0].is_mul) mul_busy = 0;
      if (mul_busy) chk("in_ready_busy", 32'(in_ready), 32'd0);
      else          chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_valid: got out_valid 1 expected 0 (nothing outstanding) at %0t", $time);
        end else begin
          e = exp_q[0];
          chk("Op",      32'(Op),      32'(e.op));
          chk("NPC",     NPC,          e.npc);
          chk("Res",     Res,          e.res);
          chk("Data",    Data,         e.data);
          chk("cond",    32'(cond),    32'(e.cond));
          chk("illegal", 32'(illegal), 32'(e.ill));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (Op_in == 6'h00 && Func_in == 6'h19) begin
          {mhi, mlo} = 64'(A_in) * 64'(B_in);
          mul_busy = 1;
        end else begin
          want_valid = 1;
        end
        exp_q.push_back(model(Op_in, Func_in, NPC_in, A_in, B_in, Imm_in, mhi, mlo));
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(negedge clk);
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] npc,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    int  n = 0;
    bit  acc = 0;
    Op_in = op; Func_in = fn; NPC_in = npc; A_in = a; B_in = b; Imm_in = imm;
    in_valid = 1'b1;
    while (!acc) begin
      #4;
      acc = in_ready;
      @(negedge clk);
      n++;
      if (!acc && n > 300) begin
        tests++; fails++;
        $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [5:0] op_tab[18] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
  logic [5:0] fn_tab[18] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h10, 6'h12, 6'h3F,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin : stim
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Op_in = '0; Func_in = '0; NPC_in = '0; A_in = '0; B_in = '0; Imm_in = '0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_Res",       Res,            32'd0);
    chk("rst_NPC",       NPC,            32'd0);
    chk("rst_cond",      32'(cond),      32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // ADD wraps, latency 1
    send(6'h00, 6'h20, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_Res",       Res,            32'h80000000);
    chk("t1_cond",      32'(cond),      32'd0);
    idle(1);

    // BEQ taken / not taken
    send(6'h04, 6'h00, 32'h100, 32'd5, 32'd5, 32'hFFFFFFFF);
    chk("t2_beq_Res",  Res,       32'h000000FC);
    chk("t2_beq_cond", 32'(cond), 32'd1);
    send(6'h04, 6'h00, 32'h100, 32'd5, 32'd6, 32'hFFFFFFFF);
    chk("t2_beq_nt_cond", 32'(cond), 32'd0);
    idle(1);

    // MULTU busy window and HI/LO
    send(6'h00, 6'h19, 32'h200, 32'hFFFFFFFF, 32'h2, 32'h0);
    n = 0;
    while (n < 100) begin
      #4;
      if (in_ready) break;
      n++;
      @(negedge clk);
    end
    chk("t3_busy_cycles", 32'(n), 32'd32);
    chk("t3_out_valid",   32'(out_valid), 32'd1);
    chk("t3_Res",         Res, 32'hFFFFFFFE);
    @(negedge clk);
    send(6'h00, 6'h10, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t3_mfhi", Res, 32'h1);
    send(6'h00, 6'h12, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t3_mflo", Res, 32'hFFFFFFFE);
    idle(2);

    // Backpressure: frozen outputs, then simultaneous consume + accept
    out_ready = 1'b0;
    send(6'h00, 6'h20, 32'h300, 32'd3, 32'd4, 32'h0);
    Op_in = 6'h00; Func_in = 6'h22; NPC_in = 32'h304; A_in = 32'd10; B_in = 32'd4; Imm_in = '0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #4;
      chk("t4_in_ready_stall", 32'(in_ready), 32'd0);
      chk("t4_Res_frozen",     Res,           32'd7);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #4;
    chk("t4_in_ready_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_b2b_out_valid", 32'(out_valid), 32'd1);
    chk("t4_b2b_Res",       Res,            32'd6);
    idle(2);

    // Reset in the middle of a multiply
    send(6'h00, 6'h19, 32'h400, 32'h12345678, 32'h9ABCDEF0, 32'h0);
    idle(9);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_Res",       Res,            32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    send(6'h00, 6'h10, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t5_hi", Res, 32'd0);
    send(6'h00, 6'h12, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t5_lo", Res, 32'd0);
    send(6'h00, 6'h20, 32'h0, 32'd1, 32'd1, 32'h0);
    chk("t5_add", Res, 32'd2);
    idle(1);

    // Illegal opcode and J
    send(6'h3F, 6'h00, 32'h500, 32'h11, 32'h22, 32'h33);
    chk("t6_illegal",     32'(illegal), 32'd1);
    chk("t6_illegal_Res", Res,          32'd0);
    chk("t6_illegal_NPC", NPC,          32'h500);
    send(6'h02, 6'h00, 32'h40000004, 32'h0, 32'h0, 32'h0000123);
    chk("t6_j_Res",  Res,       32'h4000048C);
    chk("t6_j_cond", 32'(cond), 32'd1);
    idle(2);

    // Randomized stream with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int          sel;
      logic [5:0]  op, fn;
      logic [31:0] a, b, imm;
      sel = $urandom_range(0, 19);
      if (sel < 18) begin op = op_tab[sel]; fn = fn_tab[sel]; end
      else if (sel == 18) begin op = 6'h00; fn = 6'h19; end
      else begin op = 6'($urandom); fn = 6'($urandom); end
      a   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(16'($urandom)));
      send(op, fn, $urandom & 32'hFFFFFFFC, a, b, imm);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
